// File: rtl/spi_slave_word.sv
`timescale 1ns/1ps
// spi_slave_word: word-wide SPI slave for all four modes, oversampled in i_Clk with no SCK-clocked logic.
// Define SPI_SLAVE_WORD_COUNT_EN to build the RX/TX word counters; otherwise they read 0.
module spi_slave_word #(
  parameter int SPI_MODE   = 0,
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_TX_Valid,
  input  logic [WORD_WIDTH-1:0] i_TX_Data,
  output logic                  o_TX_Ready,
  output logic                  o_RX_Valid,
  output logic [WORD_WIDTH-1:0] o_RX_Data,
  output logic                  o_TX_Underrun,
  output logic                  o_Frame_Abort,
  output logic [CNT_WIDTH-1:0]  o_RX_Count,
  output logic [CNT_WIDTH-1:0]  o_TX_Count,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_MOSI,
  input  logic                  i_SPI_CS_n,
  output logic                  o_SPI_MISO
);
  localparam bit CPOL = (SPI_MODE & 2) != 0;
  localparam bit CPHA = (SPI_MODE & 1) != 0;
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WORD_WIDTH - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [2:0] sck_q, mosi_q, cs_q;
  logic sck_rise, sck_fall, sample_e, shift_e, cs_fall, cs_rise;
  logic start, stop, do_sample, do_shift, consume, wr;
  logic [WORD_WIDTH-1:0] hold, tx_shift, rx_shift, rx_next;
  logic hold_full, word_done, first_shift, rx_pend;
  logic [BW-1:0] bit_cnt;

  // CS sync resets low so a frame only starts after CS_n has been seen high
  always_ff @(posedge i_Clk)
    if (!i_Rst_L) begin
      sck_q  <= {3{CPOL}};
      mosi_q <= '0;
      cs_q   <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], i_SPI_Clk};
      mosi_q <= {mosi_q[1:0], i_SPI_MOSI};
      cs_q   <= {cs_q[1:0], i_SPI_CS_n};
    end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign sample_e = (CPOL ^ CPHA) ? sck_fall : sck_rise;
  assign shift_e  = (CPOL ^ CPHA) ? sck_rise : sck_fall;
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  always_ff @(posedge i_Clk)
    if (!i_Rst_L) state <= IDLE;
    else state <= state_n;

  always_comb
    state_n = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);

  always_comb begin
    start     = (state == IDLE) && cs_fall;
    stop      = (state == ACTIVE) && cs_rise;
    do_sample = (state == ACTIVE) && !cs_rise && sample_e;
    do_shift  = (state == ACTIVE) && !cs_rise && shift_e;
    consume   = start || (do_shift && word_done);
  end

  assign o_TX_Ready = ~hold_full;
  assign wr         = i_TX_Valid & o_TX_Ready;
  assign rx_next    = {rx_shift[WORD_WIDTH-2:0], mosi_q[2]};
  assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : tx_shift[WORD_WIDTH-1];

  always_ff @(posedge i_Clk)
    if (!i_Rst_L) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      word_done     <= 1'b0;
      first_shift   <= 1'b0;
      rx_pend       <= 1'b0;
      o_RX_Data     <= '0;
      o_RX_Valid    <= 1'b0;
      o_TX_Underrun <= 1'b0;
      o_Frame_Abort <= 1'b0;
    end else begin
      o_RX_Valid    <= rx_pend;
      rx_pend       <= 1'b0;
      o_TX_Underrun <= consume & ~hold_full;
      o_Frame_Abort <= stop && (bit_cnt != '0);
      if (wr) hold <= i_TX_Data;
      hold_full <= wr | (hold_full & ~consume);
      // a consume always takes the pre-write holding contents
      if (state == IDLE || consume) tx_shift <= hold_full ? hold : '0;
      else if (do_shift && !(CPHA && first_shift)) tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
      if (start || stop) begin
        bit_cnt     <= '0;
        word_done   <= 1'b0;
        first_shift <= 1'b1;
      end else begin
        if (do_shift) begin
          first_shift <= 1'b0;
          word_done   <= 1'b0;
        end
        if (do_sample) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST) begin
            o_RX_Data <= rx_next;
            rx_pend   <= 1'b1;
            bit_cnt   <= '0;
            word_done <= 1'b1;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end

`ifdef SPI_SLAVE_WORD_COUNT_EN
  always_ff @(posedge i_Clk)
    if (!i_Rst_L) begin
      o_RX_Count <= '0;
      o_TX_Count <= '0;
    end else begin
      if (o_RX_Valid) o_RX_Count <= o_RX_Count + 1'b1;
      if (consume && hold_full) o_TX_Count <= o_TX_Count + 1'b1;
    end
`else
  assign o_RX_Count = '0;
  assign o_TX_Count = '0;
`endif
endmodule

// File: tb/tb_spi_slave_word.sv
`timescale 1ns/1ps
// tb_spi_slave_word: bit-banged master against four 8-bit slaves (modes 0-3) and one 16-bit mode-3 slave.
module tb_spi_slave_word;
  localparam int HALF = 10;
  typedef struct {int mode; logic [7:0] tx; logic [7:0] mo; logic [7:0] exp_mi; logic [7:0] exp_rx;} vec_t;
  typedef struct {int inst; logic [15:0] d;} rx_t;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0;
  logic [4:0] cs_n = '1, tx_v = '0;
  logic [15:0] tx_d = '0;
  logic [4:0] rdy, rxv, und, abt;
  wire  [4:0] miso;
  logic [7:0] rxd8 [4];
  logic [15:0] rxd16;
  logic [1:0] rxc [5], txc [5];
  int n_cmp = 0, n_bad = 0, sel = 0, rd = 0, obs_n = 0;
  int obs_i [256];
  logic [15:0] obs_d [256];
  time obs_tm [256];
  int und_n [5], abt_n [5], rdyl_n [5];
  logic [15:0] feed [$];
  rx_t exp_q [$];
  vec_t v [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_w8
    spi_slave_word #(.SPI_MODE(g), .WORD_WIDTH(8), .CNT_WIDTH(2)) u_dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Valid(tx_v[g]), .i_TX_Data(tx_d[7:0]),
      .o_TX_Ready(rdy[g]), .o_RX_Valid(rxv[g]), .o_RX_Data(rxd8[g]),
      .o_TX_Underrun(und[g]), .o_Frame_Abort(abt[g]), .o_RX_Count(rxc[g]), .o_TX_Count(txc[g]),
      .i_SPI_Clk(g >= 2 ? ~sck : sck), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n[g]), .o_SPI_MISO(miso[g]));
  end

  spi_slave_word #(.SPI_MODE(3), .WORD_WIDTH(16), .CNT_WIDTH(2)) u_w16 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Valid(tx_v[4]), .i_TX_Data(tx_d),
    .o_TX_Ready(rdy[4]), .o_RX_Valid(rxv[4]), .o_RX_Data(rxd16),
    .o_TX_Underrun(und[4]), .o_Frame_Abort(abt[4]), .o_RX_Count(rxc[4]), .o_TX_Count(txc[4]),
    .i_SPI_Clk(~sck), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n[4]), .o_SPI_MISO(miso[4]));

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (rxv[i] && obs_n < 256) begin
        obs_i[obs_n] = i;
        obs_d[obs_n] = (i < 4) ? {8'h00, rxd8[i[1:0]]} : rxd16;
        obs_tm[obs_n] = $time;
        obs_n++;
      end
      und_n[i] += int'(und[i]);
      abt_n[i] += int'(abt[i]);
      rdyl_n[i] += int'(!rdy[i]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion within budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx_v != '0) tx_v = '0;
      else if (feed.size() > 0 && rdy[sel]) begin
        tx_d = feed.pop_front();
        tx_v[sel] = 1'b1;
      end
    end
  endtask

  task automatic preload(input int inst, input logic [15:0] d);
    sel = inst;
    feed.push_back(d);
    for (int k = 0; k < 20 && rdy[inst]; k++) tick(1);
    check("preload_ready", 64'(rdy[inst]), 64'd0);
  endtask

  task automatic frame(input int inst, input int mode, input int nbits, input logic [63:0] mo,
                       output logic [63:0] mi, output time tl);
    mi = '0;
    tl = 0;
    if ((mode & 1) == 0) mosi = mo[nbits-1];
    cs_n[inst] = 1'b0;
    tick(HALF);
    for (int k = 0; k < nbits; k++) begin
      if ((mode & 1) != 0) begin
        sck = 1'b1;
        mosi = mo[nbits-1-k];
        tick(HALF);
        mi = {mi[62:0], miso[inst]};
        sck = 1'b0;
        tl = $time;
        tick(HALF);
      end else begin
        mi = {mi[62:0], miso[inst]};
        sck = 1'b1;
        tl = $time;
        tick(HALF);
        sck = 1'b0;
        if (k < nbits - 1) mosi = mo[nbits-2-k];
        tick(HALF);
      end
    end
    tick(HALF);
    cs_n[inst] = 1'b1;
    tick(2 * HALF);
    feed.delete();
  endtask

  task automatic drain();
    rx_t e;
    int waited = 0;
    while (exp_q.size() > 0) begin
      if (rd < obs_n) begin
        e = exp_q.pop_front();
        check("rx_inst", 64'(obs_i[rd]), 64'(e.inst));
        check("rx_data", 64'(obs_d[rd]), 64'(e.d));
        rd++;
      end else if (waited > 200) begin
        check("rx_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end else begin
        waited++;
        tick(1);
      end
    end
    check("rx_extra", 64'(obs_n), 64'(rd));
  endtask

  initial begin
    logic [63:0] mi;
    time tl;
    int m, u0, a0, r0;
    v[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    v[1] = '{1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    v[2] = '{2, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    v[3] = '{3, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    v[4] = '{0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    v[5] = '{2, 8'hFF, 8'h00, 8'hFF, 8'h00};
    v[6] = '{3, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    v[7] = '{1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    tick(3);
    for (int i = 0; i < 5; i++) begin
      check("rst_ready", 64'(rdy[i]), 64'd1);
      check("rst_rx_count", 64'(rxc[i]), 64'd0);
      check("rst_tx_count", 64'(txc[i]), 64'd0);
    end
    check("rst_rx_valid", 64'(rxv), 64'd0);
    check("rst_rx_data0", 64'(rxd8[0]), 64'd0);
    check("rst_rx_data4", 64'(rxd16), 64'd0);
    check("rst_underrun", 64'(und), 64'd0);
    check("rst_abort", 64'(abt), 64'd0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 8; i++) begin
      m = v[i].mode;
      u0 = und_n[m];
      preload(m, {8'h00, v[i].tx});
      if ((m & 1) == 0) feed.push_back(16'h0000);
      exp_q.push_back('{m, {8'h00, v[i].exp_rx}});
      frame(m, m, 8, {56'h0, v[i].mo}, mi, tl);
      check("miso_word", 64'(mi[7:0]), 64'(v[i].exp_mi));
      check("no_underrun", 64'(und_n[m] - u0), 64'd0);
      check("ready_after", 64'(rdy[m]), 64'd1);
      drain();
      if (i == 0 && rd > 0) check("rx_latency", 64'(obs_tm[rd-1] - tl), 64'd40);
    end

    u0 = und_n[4];
    preload(4, 16'h1234);
    feed.push_back(16'hBEEF);
    exp_q.push_back('{4, 16'hCAFE});
    exp_q.push_back('{4, 16'h0F0F});
    frame(4, 3, 32, 64'hCAFE_0F0F, mi, tl);
    check("w16_miso", 64'(mi[31:0]), 64'h1234_BEEF);
    check("w16_no_underrun", 64'(und_n[4] - u0), 64'd0);
    drain();

    u0 = und_n[1];
    r0 = rdyl_n[1];
    exp_q.push_back('{1, 16'h0096});
    frame(1, 1, 8, 64'h96, mi, tl);
    check("empty_miso", 64'(mi[7:0]), 64'd0);
    check("empty_underrun", 64'(und_n[1] - u0), 64'd1);
    check("empty_ready_held", 64'(rdyl_n[1] - r0), 64'd0);
    drain();

    a0 = abt_n[0];
    preload(0, 16'h00F0);
    frame(0, 0, 5, 64'h16, mi, tl);
    check("abort_miso", 64'(mi[4:0]), 64'h1E);
    check("abort_pulse", 64'(abt_n[0] - a0), 64'd1);
    drain();
    preload(0, 16'h003C);
    feed.push_back(16'h0000);
    exp_q.push_back('{0, 16'h0081});
    frame(0, 0, 8, 64'h81, mi, tl);
    check("post_abort_miso", 64'(mi[7:0]), 64'h3C);
    check("post_abort_clean", 64'(abt_n[0] - a0), 64'd1);
    drain();

    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    preload(0, 16'h0011);
    feed.push_back(16'h0022);
    feed.push_back(16'h0033);
    feed.push_back(16'h0044);
    feed.push_back(16'h0055);
    for (int i = 1; i <= 5; i++) exp_q.push_back('{0, 16'(i)});
    frame(0, 0, 40, 64'h01_0203_0405, mi, tl);
    check("cnt_miso", mi, 64'h11_2233_4455);
    drain();
`ifdef SPI_SLAVE_WORD_COUNT_EN
    check("rx_count_wrap", 64'(rxc[0]), 64'd1);
    check("tx_count_wrap", 64'(txc[0]), 64'd1);
`else
    check("rx_count_off", 64'(rxc[0]), 64'd0);
    check("tx_count_off", 64'(txc[0]), 64'd0);
`endif
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("rx_count_clr", 64'(rxc[0]), 64'd0);
    check("tx_count_clr", 64'(txc[0]), 64'd0);
    check("ready_clr", 64'(rdy[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
